// File: rtl/flag_stack.sv
// flag_stack: status flag register with a shadow stack. The stack saves and
// restores the flags across interrupt entry and return.
// Optional feature: define FLAG_STACK_ERR_EN to get the sticky overflow and
// underflow error flags. Without it STK_OVF/STK_UNF are constant 0, and a
// push while full or a pop while empty is still dropped.
module flag_stack #(
  parameter int NFLAGS = 2,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NFLAGS-1:0] FLG_IN,
  input  logic [NFLAGS-1:0] FLG_SET,
  input  logic [NFLAGS-1:0] FLG_CLR,
  input  logic [NFLAGS-1:0] FLG_LD,
  input  logic              FLG_LD_SEL,
  input  logic              FLG_PUSH,
  input  logic              FLG_POP,
  output logic [NFLAGS-1:0] FLAGS,
  output logic [CW-1:0]     STK_CNT,
  output logic              STK_EMPTY,
  output logic              STK_FULL,
  output logic              STK_OVF,
  output logic              STK_UNF
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NFLAGS-1:0] stack_q [DEPTH];
  logic [NFLAGS-1:0] tos;
  logic [AW-1:0]     tos_idx;
  logic [AW-1:0]     wr_idx;
  logic              wr_en;
  logic              empty, full;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);
  assign tos_idx = AW'(cnt_q - CW'(1));
  // An empty stack reads as zero, so entries left over from before a reset stay hidden.
  assign tos     = empty ? '0 : stack_q[tos_idx];

  // Per-bit next flag value, priority clear > set > load.
  always_comb begin
    // NOTE: every always_comb output is given a default first so that no path infers a latch.
    flags_d = flags_q;
    for (int i = 0; i < NFLAGS; i++) begin
      if (FLG_CLR[i])     flags_d[i] = 1'b0;
      else if (FLG_SET[i]) flags_d[i] = 1'b1;
      else if (FLG_LD[i])  flags_d[i] = FLG_LD_SEL ? tos[i] : FLG_IN[i];
    end
  end

  // Stack pointer and write port. Push+pop on a non-empty stack replaces the TOS.
  always_comb begin
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = AW'(cnt_q);
    if (FLG_PUSH && FLG_POP && !empty) begin
      wr_en  = 1'b1;
      wr_idx = tos_idx;
    end else if (FLG_PUSH) begin
      if (!full) begin
        wr_en = 1'b1;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (FLG_POP) begin
      if (!empty) cnt_d = cnt_q - CW'(1);
    end
  end

  // Flag and count registers. A synchronous reset overrides every request.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so that all registers sample pre-edge values.
    if (RST) begin
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow stack storage. A push always saves the flags as they were before the edge.
  always_ff @(posedge CLK) begin
    // NOTE: stack storage is not reset; the count returns to 0 and the zero-TOS read masks stale data.
    if (wr_en) stack_q[wr_idx] <= flags_q;
  end

`ifdef FLAG_STACK_ERR_EN
  logic ovf_q, unf_q;
  logic ovf_evt, unf_evt;

  assign ovf_evt = FLG_PUSH && !FLG_POP && full;
  assign unf_evt = FLG_POP && !FLG_PUSH && empty;

  // Sticky error flags. Only reset clears them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_evt) ovf_q <= 1'b1;
      if (unf_evt) unf_q <= 1'b1;
    end
  end

  assign STK_OVF = ovf_q;
  assign STK_UNF = unf_q;
`else
  assign STK_OVF = 1'b0;
  assign STK_UNF = 1'b0;
`endif

  assign FLAGS     = flags_q;
  assign STK_CNT   = cnt_q;
  assign STK_EMPTY = empty;
  assign STK_FULL  = full;

endmodule
